// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the masked SRAM bank.
//   state_t      - clear-sweep controller states
//   addr_w()     - address width for a given depth, never below 1
//   nlane()      - number of write-mask lanes in a word
//   lane_cfg_ok  - word width is a whole number of lanes
//   rd_lat_ok    - read latency is one of the supported values
package sram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int addr_w(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int nlane(input int width, input int lane_w);
        return width / lane_w;
    endfunction

    function automatic bit lane_cfg_ok(input int width, input int lane_w);
        return (lane_w > 0) && (width >= lane_w) && ((width % lane_w) == 0);
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat == 1) || (rd_lat == 2);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline for the SRAM bank. Carries the array read result and
// its valid flag through RD_LAT register stages; reset empties every stage
// so reads in flight never produce a q_valid.
//   clk      - clock, rising edge
//   reset    - synchronous, active-high; clears q, q_valid and any stage
//   rd_en    - a read is being issued at this edge
//   rd_data  - array word for the read being issued
//   q        - read data, holds its value when no read completes
//   q_valid  - high for the one cycle q carries a fresh result
module sram_rd_pipe #(
    parameter int RD_LAT = 1,
    parameter int WIDTH  = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    q       <= '0;
                    q_valid <= 1'b0;
                end else begin
                    q_valid <= rd_en;
                    if (rd_en) begin
                        q <= rd_data;
                    end
                end
            end
        end else begin : g_lat2
            logic [WIDTH-1:0] stg_data;
            logic             stg_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    stg_data  <= '0;
                    stg_valid <= 1'b0;
                    q         <= '0;
                    q_valid   <= 1'b0;
                end else begin
                    stg_valid <= rd_en;
                    if (rd_en) begin
                        stg_data <= rd_data;
                    end
                    q_valid <= stg_valid;
                    if (stg_valid) begin
                        q <= stg_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sram_mask_bank.sv
// Single-port SRAM bank with per-lane write mask, 1- or 2-cycle registered
// read and an optional zeroing sweep after reset.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | writing zero to word[ptr] each cycle, requests ignored
//   ST_READY | idle / serving requests
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous, active-high
//   CEN      - chip enable, active-low
//   WEN      - write enable, active-low (1 = read)
//   A        - word address
//   D        - write data
//   M        - per-lane write enable, bit i covers D[i*LANE_W +: LANE_W]
//   Q        - registered read data
//   q_valid  - high for the cycle Q carries a fresh read result
//   busy     - high during reset and the clear sweep; requests ignored
module sram_mask_bank
    import sram_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int WIDTH        = 128,
    parameter int LANE_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int CLR_ON_RESET = 1,
    localparam int ADDR_W      = addr_w(DEPTH),
    localparam int NLANE       = nlane(WIDTH, LANE_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CEN,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [WIDTH-1:0]  D,
    input  logic [NLANE-1:0]  M,
    output logic [WIDTH-1:0]  Q,
    output logic              q_valid,
    output logic              busy
);

    generate
        if (!lane_cfg_ok(WIDTH, LANE_W)) begin : g_bad_lane
            $error("sram_mask_bank: WIDTH must be a multiple of LANE_W");
        end
        if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
            $error("sram_mask_bank: RD_LAT must be 1 or 2");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              clr_we;

    logic              in_range;
    logic              wr_en;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= (CLR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we  = 1'b1;
                ptr_nxt = ptr + 1'b1;
                if (ptr == PTR_LAST) begin
                    state_nxt = ST_READY;
                    ptr_nxt   = '0;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_READY;
            end
        endcase
    end

    // busy follows reset combinationally so the controller is held off in
    // the very cycle reset is raised, not one edge later.
    assign busy     = reset | (state == ST_CLEAR);
    assign in_range = ({1'b0, A} < DEPTH_X);
    assign wr_en    = !busy && !CEN && !WEN && in_range;
    assign rd_en    = !busy && !CEN && WEN;

    // Out-of-range reads still complete, returning zero instead of an
    // undefined array element.
    assign rd_data  = in_range ? mem[A] : '0;

    // No reset on the array: reset itself never changes stored words.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem[ptr] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NLANE; i++) begin
                    if (M[i]) begin
                        mem[A][i*LANE_W +: LANE_W] <= D[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    sram_rd_pipe #(
        .RD_LAT (RD_LAT),
        .WIDTH  (WIDTH)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .q       (Q),
        .q_valid (q_valid)
    );

endmodule
